// File: rtl/mm_cdr_loop_if.sv
// ADC frame bus feeding the Mueller-Muller CDR loop: one frame of parallel codes plus a qualifier.
interface mm_cdr_loop_if #(
    parameter int unsigned numChannels  = 16,
    parameter int unsigned codeBitwidth = 8
);
    logic signed [codeBitwidth-1:0] data_i [numChannels];
    logic                           valid_i;

    modport master (output data_i, output valid_i);
    modport slave  (input  data_i, input  valid_i);
endinterface

// File: rtl/mm_cdr_loop.sv
// Channelized Mueller-Muller timing-recovery loop: 3-stage pipelined phase detector feeding a
// wrapping phase accumulator, with acquire/track gain selection and lock detection.
module mm_cdr_loop #(
    parameter int unsigned numChannels     = 16,
    parameter int unsigned codeBitwidth    = 8,
    parameter int unsigned piBitwidth      = 8,
    parameter int unsigned fracBitwidth    = 4,
    parameter int unsigned shiftBitwidth   = 4,
    parameter int unsigned lockCntBitwidth = 8,
    localparam int unsigned SumW           = codeBitwidth + 2 + $clog2(numChannels)
) (
    input  logic                       clk,
    input  logic                       rstb,
    mm_cdr_loop_if.slave               adc,
    input  logic                       en_i,
    input  logic [piBitwidth-1:0]      pi_init,
    input  logic [shiftBitwidth-1:0]   acq_shift,
    input  logic [shiftBitwidth-1:0]   trk_shift,
    input  logic [SumW-1:0]            lock_thresh,
    input  logic [lockCntBitwidth-1:0] lock_cnt,
    output logic [piBitwidth-1:0]      pi_ctl,
    output logic signed [SumW-1:0]     pd_sum_o,
    output logic [1:0]                 state_o,
    output logic                       locked_o
);
    localparam int unsigned TermW = codeBitwidth + 2;
    localparam int unsigned AccW  = piBitwidth + fracBitwidth;
    localparam int unsigned ExtW  = SumW - TermW;

    typedef enum logic [1:0] {StIdle = 2'b00, StAcquire = 2'b01, StTrack = 2'b10} state_e;

    state_e                         state_q;
    logic [AccW-1:0]                phase_q;
    logic [lockCntBitwidth-1:0]     cnt_q;
    logic signed [codeBitwidth-1:0] x_prev_q;
    logic                           v1_q, v2_q;
    logic signed [TermW-1:0]        term_q [numChannels];
    logic signed [SumW-1:0]         pd_q;

    logic signed [TermW-1:0] cur_x  [numChannels];
    logic signed [TermW-1:0] prv_x  [numChannels];
    logic signed [TermW-1:0] term_d [numChannels];
    logic signed [SumW-1:0]  sum_d;

    always_comb begin
        for (int k = 0; k < numChannels; k++) begin
            cur_x[k] = {{2{adc.data_i[k][codeBitwidth-1]}}, adc.data_i[k]};
        end
        prv_x[0] = {{2{x_prev_q[codeBitwidth-1]}}, x_prev_q};
        for (int k = 1; k < numChannels; k++) begin
            prv_x[k] = cur_x[k-1];
        end
        // t_k = sgn(x_k)*x_{k-1} - sgn(x_{k-1})*x_k, zero treated as positive
        for (int k = 0; k < numChannels; k++) begin
            term_d[k] = (cur_x[k][TermW-1] ? -prv_x[k] : prv_x[k])
                      - (prv_x[k][TermW-1] ? -cur_x[k] : cur_x[k]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < numChannels; k++) begin
            sum_d = sum_d + {{ExtW{term_q[k][TermW-1]}}, term_q[k]};
        end
    end

    // Stages 1-2: term and sum registers; dropping en_i flushes everything in flight.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            x_prev_q <= '0;
            pd_q     <= '0;
            for (int k = 0; k < numChannels; k++) term_q[k] <= '0;
        end else begin
            v1_q <= en_i & adc.valid_i;
            v2_q <= en_i & v1_q;
            if (!en_i) begin
                x_prev_q <= '0;
            end else if (adc.valid_i) begin
                x_prev_q <= adc.data_i[numChannels-1];
            end
            if (en_i && adc.valid_i) term_q <= term_d;
            if (en_i && v1_q) pd_q <= sum_d;
        end
    end

    logic [shiftBitwidth-1:0]   shift;
    logic signed [SumW-1:0]     shifted;
    logic [AccW-1:0]            step;
    logic [SumW-1:0]            pd_abs;
    logic                       pd_good;
    logic [lockCntBitwidth-1:0] cnt_inc;
    logic [lockCntBitwidth-1:0] cnt_target;

    always_comb begin
        shift      = (state_q == StTrack) ? trk_shift : acq_shift;
        shifted    = pd_q >>> shift;
        step       = AccW'(shifted);
        pd_abs     = pd_q[SumW-1] ? -pd_q : pd_q;
        pd_good    = (pd_abs <= lock_thresh);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        cnt_target = (lock_cnt == '0) ? lockCntBitwidth'(1) : lock_cnt;
    end

    // Stage 3: loop filter and lock FSM; the update's shift follows the pre-transition state.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= StIdle;
            phase_q <= '0;
            cnt_q   <= '0;
        end else if (!en_i) begin
            state_q <= StIdle;
            phase_q <= {pi_init, {fracBitwidth{1'b0}}};
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    phase_q <= {pi_init, {fracBitwidth{1'b0}}};
                    cnt_q   <= '0;
                    state_q <= StAcquire;
                end
                StAcquire: begin
                    if (v2_q) begin
                        phase_q <= phase_q + step;
                        if (!pd_good) begin
                            cnt_q <= '0;
                        end else if (cnt_inc >= cnt_target) begin
                            cnt_q   <= '0;
                            state_q <= StTrack;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StTrack: begin
                    if (v2_q) begin
                        phase_q <= phase_q + step;
                        if (pd_good) begin
                            cnt_q <= '0;
                        end else if (cnt_inc >= cnt_target) begin
                            cnt_q   <= '0;
                            state_q <= StAcquire;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pi_ctl   = phase_q[AccW-1 -: piBitwidth];
    assign pd_sum_o = pd_q;
    assign state_o  = state_q;
    assign locked_o = (state_q == StTrack);
endmodule

// File: tb/tb_mm_cdr_loop.sv
// Directed bench for mm_cdr_loop with 4 channels; expected codes are worked out by hand per scenario.
module tb_mm_cdr_loop;
    logic        clk = 1'b0;
    logic        rstb;
    logic        en_i;
    logic [7:0]  pi_init;
    logic [3:0]  acq_shift;
    logic [3:0]  trk_shift;
    logic [11:0] lock_thresh;
    logic [7:0]  lock_cnt;
    logic [7:0]  pi_ctl;
    logic signed [11:0] pd_sum_o;
    logic [1:0]  state_o;
    logic        locked_o;

    int errors = 0;
    int checks = 0;

    mm_cdr_loop_if #(.numChannels(4), .codeBitwidth(8)) adc ();

    mm_cdr_loop #(
        .numChannels(4), .codeBitwidth(8), .piBitwidth(8), .fracBitwidth(4),
        .shiftBitwidth(4), .lockCntBitwidth(8)
    ) dut (
        .clk(clk), .rstb(rstb), .adc(adc), .en_i(en_i), .pi_init(pi_init),
        .acq_shift(acq_shift), .trk_shift(trk_shift), .lock_thresh(lock_thresh),
        .lock_cnt(lock_cnt), .pi_ctl(pi_ctl), .pd_sum_o(pd_sum_o), .state_o(state_o),
        .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: all zero, 1: [40,10,-40,-10], 2: all -10
    task automatic set_frame(input int f);
        for (int k = 0; k < 4; k++) begin
            case (f)
                1: adc.data_i[k] = (k == 0) ? 8'sd40 : (k == 1) ? 8'sd10 :
                                   (k == 2) ? -8'sd40 : -8'sd10;
                2: adc.data_i[k] = -8'sd10;
                default: adc.data_i[k] = 8'sd0;
            endcase
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        en_i = 1'b0;
        adc.valid_i = 1'b0;
        set_frame(0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        en_i = 1'b1;
        pi_init = 8'h5A;
        adc.valid_i = 1'b1;
        repeat (3) begin
            for (int k = 0; k < 4; k++) adc.data_i[k] = 8'($urandom);
            tick();
        end
        checks++; if (pi_ctl !== 8'h00) begin errors++; $display("FAIL reset_pi: got %h want 00", pi_ctl); end
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked_o); end
        checks++; if (pd_sum_o !== 12'sd0) begin errors++; $display("FAIL reset_pd: got %0d want 0", pd_sum_o); end
        rstb = 1'b1;
        adc.valid_i = 1'b0;
        tick();
        checks++; if (pi_ctl !== 8'h5A) begin errors++; $display("FAIL release_pi: got %h want 5a", pi_ctl); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL release_state: got %b want 01", state_o); end
    endtask

    task automatic test_constant_pd();
        int acc;
        logic [7:0] exp_pi;
        do_reset();
        pi_init = 8'h40; acq_shift = 4'd4; trk_shift = 4'd4; lock_thresh = 12'd0; lock_cnt = 8'd4;
        en_i = 1'b1; rstb = 1'b1; adc.valid_i = 1'b1; set_frame(1);
        tick();
        checks++; if (pi_ctl !== 8'h40) begin errors++; $display("FAIL const_pi_e0: got %h want 40", pi_ctl); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL const_state_e0: got %b want 01", state_o); end
        tick();
        checks++; if (pi_ctl !== 8'h40) begin errors++; $display("FAIL const_pi_e1: got %h want 40", pi_ctl); end
        checks++; if (pd_sum_o !== 12'sd50) begin errors++; $display("FAIL const_pd_first: got %0d want 50", pd_sum_o); end
        for (int k = 0; k <= 20; k++) begin
            tick();
            acc = 1027 + 7 * k;  // 0x400 + 3 from the first frame, then +7 per frame
            exp_pi = acc[11:4];
            checks++; if (pi_ctl !== exp_pi) begin errors++; $display("FAIL const_pi_k%0d: got %h want %h", k, pi_ctl, exp_pi); end
            if (k == 0) begin
                checks++; if (pd_sum_o !== 12'sd120) begin errors++; $display("FAIL const_pd_steady: got %0d want 120", pd_sum_o); end
            end
        end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL const_state_end: got %b want 01", state_o); end
    endtask

    task automatic test_wrap();
        int acc;
        logic [7:0] exp_pi;
        do_reset();
        pi_init = 8'hFF; acq_shift = 4'd4; lock_thresh = 12'd0; lock_cnt = 8'd4;
        en_i = 1'b1; rstb = 1'b1; adc.valid_i = 1'b1; set_frame(1);
        tick();
        tick();
        checks++; if (pi_ctl !== 8'hFF) begin errors++; $display("FAIL wrap_pi_e1: got %h want ff", pi_ctl); end
        for (int k = 0; k <= 5; k++) begin
            tick();
            acc = (4083 + 7 * k) % 4096;
            exp_pi = acc[11:4];
            checks++; if (pi_ctl !== exp_pi) begin errors++; $display("FAIL wrap_pi_k%0d: got %h want %h", k, pi_ctl, exp_pi); end
        end
    endtask

    task automatic test_lock();
        int         frames [15];
        logic [7:0] exp_pi [15];
        logic [1:0] exp_st [15];
        frames = '{0, 0, 0, 0, 1, 1, 1, 2, 1, 1, 1, 1, -1, -1, -1};
        exp_pi = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h82, 8'h84, 8'h84,
                   8'h86, 8'h88, 8'h8A, 8'h8C, 8'h8C};
        exp_st = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                   2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        pi_init = 8'h80; acq_shift = 4'd4; trk_shift = 4'd2; lock_thresh = 12'd2; lock_cnt = 8'd4;
        en_i = 1'b1; rstb = 1'b1;
        for (int e = 0; e < 15; e++) begin
            adc.valid_i = (frames[e] >= 0);
            set_frame(frames[e] >= 0 ? frames[e] : 0);
            tick();
            checks++; if (pi_ctl !== exp_pi[e]) begin errors++; $display("FAIL lock_pi_e%0d: got %h want %h", e, pi_ctl, exp_pi[e]); end
            checks++; if (state_o !== exp_st[e]) begin errors++; $display("FAIL lock_state_e%0d: got %b want %b", e, state_o, exp_st[e]); end
            checks++; if (locked_o !== (exp_st[e] == 2'd2)) begin errors++; $display("FAIL lock_locked_e%0d: got %b want %b", e, locked_o, exp_st[e] == 2'd2); end
            if (e == 5) begin
                checks++; if (pd_sum_o !== 12'sd50) begin errors++; $display("FAIL lock_pd_e5: got %0d want 50", pd_sum_o); end
            end
            if (e == 8) begin
                checks++; if (pd_sum_o !== 12'sd0) begin errors++; $display("FAIL lock_pd_e8: got %0d want 0", pd_sum_o); end
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0]        exp_pi [10];
        logic signed [11:0] exp_pd [10];
        exp_pi = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41};
        exp_pd = '{12'sd0, 12'sd50, 12'sd50, 12'sd120, 12'sd120, 12'sd120, 12'sd120, 12'sd120,
                   12'sd120, 12'sd120};
        do_reset();
        pi_init = 8'h40; acq_shift = 4'd4; lock_thresh = 12'd0; lock_cnt = 8'd4;
        en_i = 1'b1; rstb = 1'b1; set_frame(1);
        for (int e = 0; e < 10; e++) begin
            adc.valid_i = (e % 2 == 0);
            tick();
            checks++; if (pi_ctl !== exp_pi[e]) begin errors++; $display("FAIL gaps_pi_e%0d: got %h want %h", e, pi_ctl, exp_pi[e]); end
            checks++; if (pd_sum_o !== exp_pd[e]) begin errors++; $display("FAIL gaps_pd_e%0d: got %0d want %0d", e, pd_sum_o, exp_pd[e]); end
        end
    endtask

    task automatic test_disable();
        do_reset();
        pi_init = 8'h80; acq_shift = 4'd4; trk_shift = 4'd0; lock_thresh = 12'd2; lock_cnt = 8'd2;
        en_i = 1'b1; rstb = 1'b1; adc.valid_i = 1'b1;
        set_frame(0); tick(); tick();
        set_frame(1); tick(); tick();
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL dis_state_e3: got %b want 10", state_o); end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL dis_locked_e3: got %b want 1", locked_o); end
        tick();
        checks++; if (pi_ctl !== 8'h83) begin errors++; $display("FAIL dis_pi_e4: got %h want 83", pi_ctl); end
        en_i = 1'b0;
        tick();
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL dis_state_e5: got %b want 00", state_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL dis_locked_e5: got %b want 0", locked_o); end
        checks++; if (pi_ctl !== 8'h80) begin errors++; $display("FAIL dis_pi_e5: got %h want 80", pi_ctl); end
        en_i = 1'b1; adc.valid_i = 1'b0;
        for (int e = 6; e <= 8; e++) begin
            tick();
            checks++; if (pi_ctl !== 8'h80) begin errors++; $display("FAIL dis_pi_e%0d: got %h want 80", e, pi_ctl); end
            checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL dis_state_e%0d: got %b want 01", e, state_o); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pi_init = 8'h40; acq_shift = 4'd0; trk_shift = 4'd0; lock_thresh = 12'd0; lock_cnt = 8'd4;
        en_i = 1'b1; rstb = 1'b1; adc.valid_i = 1'b1; set_frame(1);
        tick(); tick(); tick();
        checks++; if (pi_ctl !== 8'h43) begin errors++; $display("FAIL mid_pi_e2: got %h want 43", pi_ctl); end
        rstb = 1'b0;
        tick();
        checks++; if (pi_ctl !== 8'h00) begin errors++; $display("FAIL mid_rst_pi: got %h want 00", pi_ctl); end
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL mid_rst_state: got %b want 00", state_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL mid_rst_locked: got %b want 0", locked_o); end
        checks++; if (pd_sum_o !== 12'sd0) begin errors++; $display("FAIL mid_rst_pd: got %0d want 0", pd_sum_o); end
        rstb = 1'b1; adc.valid_i = 1'b0;
        for (int e = 4; e <= 6; e++) begin
            tick();
            checks++; if (pi_ctl !== 8'h40) begin errors++; $display("FAIL mid_pi_e%0d: got %h want 40", e, pi_ctl); end
        end
        adc.valid_i = 1'b1;
        tick();
        adc.valid_i = 1'b0;
        tick();
        checks++; if (pd_sum_o !== 12'sd50) begin errors++; $display("FAIL mid_pd_fresh: got %0d want 50", pd_sum_o); end
    endtask

    initial begin
        rstb = 1'b0; en_i = 1'b0; pi_init = 8'h00; acq_shift = 4'd4; trk_shift = 4'd4;
        lock_thresh = 12'd0; lock_cnt = 8'd4; adc.valid_i = 1'b0;
        set_frame(0);
        test_reset();
        test_constant_pd();
        test_wrap();
        test_lock();
        test_gaps();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
